// File: rtl/time_pkg.sv
// Shared constants, FSM encoding and nibble helper for the digit-to-time conversion path.
package time_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned FIELD_W     = 6;
    localparam int unsigned WORK_W      = 2 * NIB_W + FIELD_W;

    localparam int unsigned SHIFT_STEPS = 6;
    localparam int unsigned HH_MAX      = 23;
    localparam int unsigned MS_MAX      = 59;

    localparam logic [NIB_W-1:0] DIG_MAX   = 4'd9;
    localparam logic [NIB_W-1:0] DIG_BLANK = 4'd10;
    localparam logic [NIB_W-1:0] DIG_DASH  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Reverse double-dabble correction: a nibble that picked up the 8-weight from above is pulled back by 3.
    function automatic logic [NIB_W-1:0] fix_nibble(input logic [NIB_W-1:0] n);
        return (n >= 4'd8) ? n - 4'd3 : n;
    endfunction

endpackage

// File: rtl/bit_to_num_if.sv
// Digit-entry side of the time converter: start request, eight digit codes and the binary result.
interface bit_to_num_if;
    import time_pkg::*;

    logic               start;
    logic [NIB_W-1:0]   bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
    logic [FIELD_W-1:0] num_02, num_01, num_00;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0,
        input  num_02, num_01, num_00, busy, done, err
    );

    modport slave (
        input  start, bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0,
        output num_02, num_01, num_00, busy, done, err
    );
endinterface

// File: rtl/bcd2_to_bin6.sv
// One two-digit BCD field converted to 6-bit binary by shift-right / subtract-3 iterations.
module bcd2_to_bin6 import time_pkg::*; (
    input  logic               sclk,
    input  logic               nrst,
    input  logic               load,
    input  logic               shift,
    input  logic               fix,
    input  logic [NIB_W-1:0]   tens,
    input  logic [NIB_W-1:0]   ones,
    output logic [FIELD_W-1:0] bin,
    output logic               bad_digit
);

    logic [WORK_W-1:0] work;

    // Working register {tens, ones, bin}; bad_digit records a non-decimal digit seen at load.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            work      <= WORK_W'(0);
            bad_digit <= 1'b0;
        end else if (load) begin
            work      <= {tens, ones, FIELD_W'(0)};
            bad_digit <= (tens > DIG_MAX) || (ones > DIG_MAX);
        end else if (shift) begin
            work      <= work >> 1;
        end else if (fix) begin
            work      <= {fix_nibble(work[WORK_W-1 -: NIB_W]),
                          fix_nibble(work[FIELD_W +: NIB_W]),
                          work[FIELD_W-1:0]};
        end
    end

    assign bin = work[FIELD_W-1:0];

endmodule

// File: rtl/bit_to_num.sv
// hh-mm-ss digit codes to binary hours/minutes/seconds with range check before publishing.
module bit_to_num #(
    parameter int unsigned SHIFT_STEPS = time_pkg::SHIFT_STEPS,
    parameter int unsigned HH_MAX      = time_pkg::HH_MAX,
    parameter int unsigned MS_MAX      = time_pkg::MS_MAX
) (
    input  logic        sclk,
    input  logic        nrst,
    bit_to_num_if.slave bus
);

    localparam int unsigned FW    = time_pkg::FIELD_W;
    localparam int unsigned CNT_W = $clog2(SHIFT_STEPS + 1);

    time_pkg::state_t state, state_d;
    logic [CNT_W-1:0] step_cnt, step_cnt_d;
    logic [FW-1:0]    num_02_q, num_01_q, num_00_q;
    logic [FW-1:0]    num_02_d, num_01_d, num_00_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             load_c, shift_c, fix_c, reject_c;
    logic [FW-1:0]    hh_bin, mm_bin, ss_bin;
    logic             hh_bad, mm_bad, ss_bad;
    logic             unused_sep;

    // Separator positions carry no value.
    assign unused_sep = ^{bus.bit_5, bus.bit_2};

    bcd2_to_bin6 u_hh (
        .sclk(sclk), .nrst(nrst), .load(load_c), .shift(shift_c), .fix(fix_c),
        .tens(bus.bit_7), .ones(bus.bit_6), .bin(hh_bin), .bad_digit(hh_bad)
    );

    bcd2_to_bin6 u_mm (
        .sclk(sclk), .nrst(nrst), .load(load_c), .shift(shift_c), .fix(fix_c),
        .tens(bus.bit_4), .ones(bus.bit_3), .bin(mm_bin), .bad_digit(mm_bad)
    );

    bcd2_to_bin6 u_ss (
        .sclk(sclk), .nrst(nrst), .load(load_c), .shift(shift_c), .fix(fix_c),
        .tens(bus.bit_1), .ones(bus.bit_0), .bin(ss_bin), .bad_digit(ss_bad)
    );

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state    <= time_pkg::S_IDLE;
            step_cnt <= CNT_W'(0);
            num_02_q <= FW'(0);
            num_01_q <= FW'(0);
            num_00_q <= FW'(0);
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            step_cnt <= step_cnt_d;
            num_02_q <= num_02_d;
            num_01_q <= num_01_d;
            num_00_q <= num_00_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Sequencing, range check and output register next values.
    always_comb begin
        state_d    = state;
        step_cnt_d = step_cnt;
        num_02_d   = num_02_q;
        num_01_d   = num_01_q;
        num_00_d   = num_00_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        fix_c      = 1'b0;
        reject_c   = hh_bad || mm_bad || ss_bad ||
                     (hh_bin > FW'(HH_MAX)) ||
                     (mm_bin > FW'(MS_MAX)) ||
                     (ss_bin > FW'(MS_MAX));

        case (state)
            time_pkg::S_IDLE: begin
                if (bus.start) begin
                    load_c     = 1'b1;
                    step_cnt_d = CNT_W'(0);
                    busy_d     = 1'b1;
                    state_d    = time_pkg::S_SHIFT;
                end
            end
            time_pkg::S_SHIFT: begin
                shift_c = 1'b1;
                state_d = time_pkg::S_FIX;
            end
            time_pkg::S_FIX: begin
                fix_c      = 1'b1;
                step_cnt_d = step_cnt + CNT_W'(1);
                state_d    = (step_cnt_d == CNT_W'(SHIFT_STEPS)) ? time_pkg::S_DONE
                                                                  : time_pkg::S_SHIFT;
            end
            time_pkg::S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = reject_c;
                if (!reject_c) begin
                    num_02_d = hh_bin;
                    num_01_d = mm_bin;
                    num_00_d = ss_bin;
                end
                state_d = time_pkg::S_IDLE;
            end
            default: state_d = time_pkg::S_IDLE;
        endcase
    end

    assign bus.num_02 = num_02_q;
    assign bus.num_01 = num_01_q;
    assign bus.num_00 = num_00_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_bit_to_num.sv
// Scoreboard bench for bit_to_num: expected results queued at start, compared on each done pulse.
module tb_bit_to_num;
    import time_pkg::*;

    typedef struct packed {
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       err;
    } exp_t;

    localparam int ACT_NONE   = 0;
    localparam int ACT_START  = 1;
    localparam int ACT_DIGITS = 2;
    localparam int ACT_RESET  = 3;

    logic sclk = 1'b0;
    logic nrst;
    bit_to_num_if bus();

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   last_h, last_m, last_s;

    always #5 sclk = ~sclk;

    bit_to_num dut (.sclk(sclk), .nrst(nrst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hms(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d,
                                        input logic [3:0] e, input logic [3:0] f);
        return {a, b, DIG_DASH, c, d, DIG_DASH, e, f};
    endfunction

    task automatic drive(input logic [31:0] d);
        bus.bit_7 = d[31:28]; bus.bit_6 = d[27:24]; bus.bit_5 = d[23:20]; bus.bit_4 = d[19:16];
        bus.bit_3 = d[15:12]; bus.bit_2 = d[11:8];  bus.bit_1 = d[7:4];   bus.bit_0 = d[3:0];
    endtask

    // Reference model: decimal digit pairs, legality and range, holding last accepted time.
    task automatic model_push(input logic [31:0] d);
        exp_t e;
        logic bad;
        int   h, m, s;
        bad = 1'b0;
        foreach (d[i]) begin
            if ((i % 4 == 0) && (i / 4 != 5) && (i / 4 != 2) && (d[i +: 4] > 4'd9)) bad = 1'b1;
        end
        h = int'(d[31:28]) * 10 + int'(d[27:24]);
        m = int'(d[19:16]) * 10 + int'(d[15:12]);
        s = int'(d[7:4])   * 10 + int'(d[3:0]);
        e.err = bad || (h > 23) || (m > 59) || (s > 59);
        if (!e.err) begin
            last_h = h; last_m = m; last_s = s;
        end
        e.h = 6'(last_h); e.m = 6'(last_m); e.s = 6'(last_s);
        sb.push_back(e);
    endtask

    always @(negedge sclk) begin
        if (nrst && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("num_02", 32'(bus.num_02), 32'(mon_e.h));
                chk("num_01", 32'(bus.num_01), 32'(mon_e.m));
                chk("num_00", 32'(bus.num_00), 32'(mon_e.s));
                chk("err",    32'(bus.err),    32'(mon_e.err));
            end
        end
    end

    task automatic convert(input logic [31:0] digs, input int act, input int act_at);
        int lat;
        int d0;
        d0 = done_cnt;
        @(negedge sclk);
        drive(digs);
        bus.start = 1'b1;
        model_push(digs);
        @(negedge sclk);
        bus.start = 1'b0;
        chk("busy_after_load", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 40) begin
            if (lat == act_at) begin
                case (act)
                    ACT_START:  bus.start = 1'b1;
                    ACT_DIGITS: drive(32'h9999_9999);
                    ACT_RESET: begin
                        nrst = 1'b0;
                        #1;
                        chk("rst_num_02", 32'(bus.num_02), 32'd0);
                        chk("rst_num_01", 32'(bus.num_01), 32'd0);
                        chk("rst_num_00", 32'(bus.num_00), 32'd0);
                        chk("rst_busy",   32'(bus.busy),   32'd0);
                        chk("rst_err",    32'(bus.err),    32'd0);
                        sb.delete();
                        last_h = 0; last_m = 0; last_s = 0;
                        @(negedge sclk);
                        nrst = 1'b1;
                        repeat (20) @(negedge sclk);
                        chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
                        chk("idle_after_reset", 32'(bus.busy), 32'd0);
                        return;
                    end
                    default: ;
                endcase
            end
            @(negedge sclk);
            lat++;
            if (act == ACT_START && lat == act_at + 1) bus.start = 1'b0;
        end
        chk("done_latency", 32'(lat), 32'd13);
        bus.start = 1'b0;
        @(negedge sclk);
        chk("done_width", 32'(bus.done), 32'd0);
        chk("busy_idle",  32'(bus.busy), 32'd0);
        repeat (16) @(negedge sclk);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    // start held high: second conversion must complete exactly 14 cycles after the first.
    task automatic back_to_back(input logic [31:0] da, input logic [31:0] db);
        int lat;
        int d0;
        d0 = done_cnt;
        @(negedge sclk);
        drive(da);
        bus.start = 1'b1;
        model_push(da);
        @(negedge sclk);
        drive(db);
        model_push(db);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge sclk);
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd13);
        lat = 0;
        do begin
            @(negedge sclk);
            lat++;
        end while (!bus.done && lat < 40);
        bus.start = 1'b0;
        chk("b2b_period", 32'(lat), 32'd14);
        repeat (16) @(negedge sclk);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] digs;
        nrst = 1'b0;
        bus.start = 1'b0;
        drive(32'h0);
        last_h = 0; last_m = 0; last_s = 0;
        repeat (3) @(negedge sclk);
        chk("reset_num_02", 32'(bus.num_02), 32'd0);
        chk("reset_num_01", 32'(bus.num_01), 32'd0);
        chk("reset_num_00", 32'(bus.num_00), 32'd0);
        chk("reset_busy",   32'(bus.busy),   32'd0);
        chk("reset_done",   32'(bus.done),   32'd0);
        chk("reset_err",    32'(bus.err),    32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge sclk);

        convert(hms(1, 2, 3, 4, 5, 6), ACT_NONE, -1);
        convert(hms(2, 3, 5, 9, 5, 9), ACT_NONE, -1);
        convert(hms(0, 0, 0, 0, 0, 0), ACT_NONE, -1);
        convert(hms(1, 2, 3, 4, 5, 6), ACT_NONE, -1);
        convert(hms(2, 4, 0, 0, 0, 0), ACT_NONE, -1);
        convert(hms(0, 0, 6, 0, 0, 0), ACT_NONE, -1);
        convert(hms(0, 0, 0, 0, 6, 3), ACT_NONE, -1);
        digs = {4'd1, 4'd2, DIG_DASH, 4'd3, DIG_BLANK, DIG_DASH, 4'd5, 4'd6};
        convert(digs, ACT_NONE, -1);
        digs = {4'd1, 4'd2, DIG_DASH, 4'd3, 4'd15, DIG_DASH, 4'd5, 4'd6};
        convert(digs, ACT_NONE, -1);
        convert(hms(0, 1, 0, 2, 0, 3), ACT_NONE, -1);
        convert(hms(1, 9, 4, 7, 3, 8), ACT_NONE, -1);
        convert(hms(1, 1, 2, 2, 3, 3), ACT_START, 4);
        convert(hms(0, 7, 0, 8, 0, 9), ACT_DIGITS, 3);
        back_to_back(hms(2, 0, 1, 5, 4, 5), hms(0, 9, 3, 0, 5, 8));
        convert(hms(1, 2, 3, 4, 5, 6), ACT_RESET, 6);
        convert(hms(0, 5, 0, 6, 0, 7), ACT_NONE, -1);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
